// File: rtl/multicycle_control.sv
// Moore controller sequencing a multi-cycle MIPS datapath (fetch/decode/execute/mem/writeback).
// Outputs decode from the state register, with instr and mem_ready folded in only where needed.
module multicycle_control (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        invert_zero,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_op,
  output logic        rtype,
  output logic [1:0]  pc_source,
  output logic [3:0]  state,
  output logic        illegal,
  output logic        halted
);

  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_READ = 4'd3, MEM_WB = 4'd4,
    MEM_WRITE = 4'd5, R_EXEC = 4'd6, R_WB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9,
    I_EXEC = 4'd10, I_WB = 4'd11, HALT = 4'd12
  } state_t;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                         OP_ADDI = 6'h08, OP_SLTI = 6'h0a, OP_ANDI = 6'h0c, OP_ORI = 6'h0d,
                         OP_LW = 6'h23, OP_SW = 6'h2b;

  localparam logic [3:0] ALU_ADD = 4'h2, ALU_SUB = 4'h6, ALU_AND = 4'h0,
                         ALU_OR = 4'h1, ALU_SLT = 4'h7;

  state_t     state_q, state_d;
  logic [5:0] opcode;

  assign opcode = instr[31:26];
  assign state  = state_q;

  always_ff @(posedge clock) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:     if (mem_ready) state_d = DECODE;
      DECODE: begin
        if (instr == 32'h0) state_d = HALT;
        else begin
          case (opcode)
            OP_R:                                state_d = R_EXEC;
            OP_LW, OP_SW:                        state_d = MEM_ADDR;
            OP_BEQ, OP_BNE:                      state_d = BRANCH;
            OP_J:                                state_d = JUMP;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:   state_d = I_EXEC;
            default:                             state_d = FETCH;
          endcase
        end
      end
      MEM_ADDR:  state_d = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  if (mem_ready) state_d = MEM_WB;
      MEM_WB:    state_d = FETCH;
      MEM_WRITE: if (mem_ready) state_d = FETCH;
      R_EXEC:    state_d = R_WB;
      R_WB:      state_d = FETCH;
      BRANCH:    state_d = FETCH;
      JUMP:      state_d = FETCH;
      I_EXEC:    state_d = I_WB;
      I_WB:      state_d = FETCH;
      HALT:      state_d = HALT;
      default:   state_d = FETCH;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    invert_zero   = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = ALU_ADD;
    rtype         = 1'b0;
    pc_source     = 2'b00;
    illegal       = 1'b0;
    halted        = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        // Branch target is precomputed here so BRANCH only needs the compare.
        alu_src_b = 2'b11;
        if (instr != 32'h0) begin
          case (opcode)
            OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
            OP_ANDI, OP_ORI, OP_LW, OP_SW: illegal = 1'b0;
            default:                       illegal = 1'b1;
          endcase
        end
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_READ: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      MEM_WRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        rtype     = 1'b1;
      end
      R_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        invert_zero   = (opcode == OP_BNE);
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (opcode)
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          OP_SLTI: alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      I_WB:    reg_write = 1'b1;
      HALT:    halted    = 1'b1;
      default: ;
    endcase
    // Reset aborts any in-flight access: no architectural state may change.
    if (reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver queues expected state/outputs per cycle,
// the monitor pops and compares them on the falling edge.
module tb_multicycle_control;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, invert_zero, iord, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a, rtype, illegal, halted;
  logic [1:0]  alu_src_b, pc_source;
  logic [3:0]  alu_op, state;

  multicycle_control dut (
    .clock(clock), .reset(reset), .instr(instr), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .invert_zero(invert_zero),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .rtype(rtype),
    .pc_source(pc_source), .state(state), .illegal(illegal), .halted(halted)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] cyc;
    logic [3:0]  st;
    logic [21:0] outs;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] cyc_n    = 0;
  logic [21:0] obs_outs;

  assign obs_outs = {pc_write, pc_write_cond, invert_zero, iord, mem_read, mem_write,
                     ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                     alu_op, rtype, pc_source, illegal, halted};

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected controller outputs for a given state, straight from the per-state output table.
  function automatic logic [21:0] exp_out(input logic [3:0] st, input logic [31:0] ins,
                                          input logic rdy, input logic rst);
    logic pw, pwc, iz, io, mr, mw, irw, rd, m2r, rw, sa, rt, ill, hl;
    logic [1:0] sb, ps;
    logic [3:0] op;
    logic [5:0] opc;
    pw = 0; pwc = 0; iz = 0; io = 0; mr = 0; mw = 0; irw = 0; rd = 0; m2r = 0; rw = 0;
    sa = 0; rt = 0; ill = 0; hl = 0; sb = 2'b00; ps = 2'b00; op = 4'h2;
    opc = ins[31:26];
    case (st)
      4'd0:  begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
      4'd1:  begin
        sb = 2'b11;
        ill = (ins != 0) && !(opc inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0a,
                                          6'h0c, 6'h0d, 6'h23, 6'h2b});
      end
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin io = 1; mr = 1; end
      4'd4:  begin m2r = 1; rw = 1; end
      4'd5:  begin io = 1; mw = 1; end
      4'd6:  begin sa = 1; rt = 1; end
      4'd7:  begin rd = 1; rw = 1; end
      4'd8:  begin sa = 1; op = 4'h6; pwc = 1; ps = 2'b01; iz = (opc == 6'h05); end
      4'd9:  begin pw = 1; ps = 2'b10; end
      4'd10: begin
        sa = 1; sb = 2'b10;
        op = (opc == 6'h0c) ? 4'h0 : (opc == 6'h0d) ? 4'h1 : (opc == 6'h0a) ? 4'h7 : 4'h2;
      end
      4'd11: rw = 1;
      4'd12: hl = 1;
      default: ;
    endcase
    if (rst) begin pw = 0; pwc = 0; irw = 0; mr = 0; mw = 0; rw = 0; end
    return {pw, pwc, iz, io, mr, mw, irw, rd, m2r, rw, sa, sb, op, rt, ps, ill, hl};
  endfunction

  // Called at posedge+1: drive this cycle's inputs, queue expectations, advance one clock.
  task automatic cyc(input logic rdy, input logic rst, input logic [3:0] exp_st);
    exp_t e;
    mem_ready = rdy;
    reset     = rst;
    e.cyc  = cyc_n;
    e.st   = exp_st;
    e.outs = exp_out(exp_st, instr, rdy, rst);
    sb_q.push_back(e);
    cyc_n++;
    @(posedge clock);
    #1;
  endtask

  task automatic run(input logic [31:0] ins, input logic [3:0] sts[$]);
    instr = ins;
    foreach (sts[i]) cyc(1'b1, 1'b0, sts[i]);
  endtask

  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk_eq($sformatf("state@%0d", e.cyc), {28'h0, state}, {28'h0, e.st});
      chk_eq($sformatf("outs@%0d", e.cyc), {10'h0, obs_outs}, {10'h0, e.outs});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; mem_ready = 1'b0; instr = 32'h0;
    @(posedge clock); #1;
    cyc(1'b1, 1'b1, 4'd0);                       // reset held: FETCH, strobes forced low

    run(32'h00851020, '{4'd0, 4'd1, 4'd6, 4'd7}); // add
    instr = 32'h8c820004;                          // lw, one FETCH wait then MEM_READ waits
    cyc(1'b0, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 4'd1);
    cyc(1'b0, 1'b0, 4'd2);                         // mem_ready ignored outside wait states
    cyc(1'b0, 1'b0, 4'd3);
    cyc(1'b0, 1'b0, 4'd3);
    cyc(1'b1, 1'b0, 4'd3);
    cyc(1'b0, 1'b0, 4'd4);

    run(32'h14850003, '{4'd0, 4'd1, 4'd8});        // bne
    run(32'h10850003, '{4'd0, 4'd1, 4'd8});        // beq
    run(32'h34820055, '{4'd0, 4'd1, 4'd10, 4'd11}); // ori
    run(32'h08100000, '{4'd0, 4'd1, 4'd9});        // j
    run(32'h28820005, '{4'd0, 4'd1, 4'd10, 4'd11}); // slti
    run(32'h30820005, '{4'd0, 4'd1, 4'd10, 4'd11}); // andi
    run(32'h20820005, '{4'd0, 4'd1, 4'd10, 4'd11}); // addi
    run(32'hfc000000, '{4'd0, 4'd1});              // illegal opcode 3f

    instr = 32'hac820004;                          // sw aborted by reset mid-wait
    cyc(1'b1, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 4'd1);
    cyc(1'b1, 1'b0, 4'd2);
    cyc(1'b0, 1'b0, 4'd5);
    cyc(1'b0, 1'b0, 4'd5);
    cyc(1'b0, 1'b1, 4'd5);
    run(32'h00851020, '{4'd0, 4'd1, 4'd6, 4'd7});  // next instruction proceeds normally
    run(32'hac820004, '{4'd0, 4'd1, 4'd2, 4'd5});  // sw completing

    run(32'h00000000, '{4'd0, 4'd1});              // halt
    for (int i = 0; i < 10; i++) cyc(1'($urandom_range(0, 1)), 1'b0, 4'd12);
    cyc(1'b1, 1'b1, 4'd12);
    cyc(1'b1, 1'b0, 4'd0);

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clock);
    if (sb_q.size() > 0) chk_eq("drain", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
